// File: rtl/aemb2_icache_if.sv
// Fetch-side bundle between the instruction fetch stage and its cache.
// Master is the fetch stage; slave is the cache.
interface aemb2_icache_if #(
  parameter int AEMB_IWB = 32
);
  logic [AEMB_IWB-3:0] ich_adr;
  logic                ich_ena;
  logic                ich_flush;
  logic                iwb_stb_o;
  logic                iwb_ack_i;
  logic [31:0]         iwb_dat_i;
  logic                ich_hit;
  logic [31:0]         ich_dat;
  logic                ich_busy;

  modport master (
    output ich_adr,
    output ich_ena,
    output ich_flush,
    output iwb_stb_o,
    output iwb_ack_i,
    output iwb_dat_i,
    input  ich_hit,
    input  ich_dat,
    input  ich_busy
  );

  modport slave (
    input  ich_adr,
    input  ich_ena,
    input  ich_flush,
    input  iwb_stb_o,
    input  iwb_ack_i,
    input  iwb_dat_i,
    output ich_hit,
    output ich_dat,
    output ich_busy
  );
endinterface

// File: rtl/aemb2_icache.sv
// Direct-mapped one-word-per-line instruction cache with
// walking invalidation after reset and on flush.
module aemb2_icache #(
  parameter int AEMB_IWB = 32,
  parameter int AEMB_ICH = 11
) (
  input  logic          gclk,
  input  logic          grst,
  aemb2_icache_if.slave ich
);
  localparam int N  = 1 << AEMB_ICH;
  localparam int TW = AEMB_IWB - 2 - AEMB_ICH;

  typedef enum logic [1:0] {
    INIT,
    RUN,
    FLUSH
  } state_t;

  state_t r_state;
  state_t w_state;

  logic [AEMB_ICH-1:0] r_cnt;
  logic [AEMB_ICH-1:0] w_cnt;

  logic [31:0]   r_dat [N];
  logic [TW-1:0] r_tag [N];
  logic          r_val [N];

  logic [AEMB_ICH-1:0] w_idx;
  logic [TW-1:0]       w_tag;
  logic                w_run;
  logic                w_last;
  logic                w_fill;

  assign w_idx  = ich.ich_adr[AEMB_ICH-1:0];
  assign w_tag  = ich.ich_adr[AEMB_IWB-3:AEMB_ICH];
  assign w_run  = (r_state == RUN);
  assign w_last = (r_cnt == {AEMB_ICH{1'b1}});

  // A flush in the same cycle as an ack wins over the fill
  assign w_fill = w_run & ich.ich_ena
                & ich.iwb_stb_o & ich.iwb_ack_i
                & ~ich.ich_flush;

  assign ich.ich_busy = ~w_run;
  assign ich.ich_dat  = r_dat[w_idx];
  assign ich.ich_hit  = w_run & ich.ich_ena
                      & r_val[w_idx]
                      & (r_tag[w_idx] == w_tag);

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    unique case (r_state)
      INIT, FLUSH: begin
        if (ich.ich_flush) begin
          w_cnt = '0;
        end else if (w_last) begin
          w_state = RUN;
          w_cnt   = '0;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      RUN: begin
        if (ich.ich_flush) begin
          w_state = FLUSH;
          w_cnt   = '0;
        end
      end
      default: begin
        w_state = INIT;
        w_cnt   = '0;
      end
    endcase
  end

  always_ff @(posedge gclk or negedge grst) begin
    if (!grst) begin
      r_state <= INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
    end
  end

  always_ff @(posedge gclk) begin
    if (!w_run) begin
      r_val[r_cnt] <= 1'b0;
    end else if (w_fill) begin
      r_val[w_idx] <= 1'b1;
      r_tag[w_idx] <= w_tag;
      r_dat[w_idx] <= ich.iwb_dat_i;
    end
  end
endmodule

// File: tb/tb_aemb2_icache.sv
// Randomized bench for aemb2_icache against a
// line-table model of the cache.
module tb_aemb2_icache;
  logic gclk = 1'b0;
  logic grst = 1'b0;

  always #5 gclk = ~gclk;

  aemb2_icache_if #(.AEMB_IWB(32)) bus ();

  aemb2_icache #(
    .AEMB_IWB(32),
    .AEMB_ICH(4)
  ) dut (
    .gclk(gclk),
    .grst(grst),
    .ich (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  logic        m_val [16];
  logic [25:0] m_tag [16];
  logic [31:0] m_dat [16];
  int          m_busy;

  logic        l_hit;
  logic        l_busy;
  logic [31:0] l_dat;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic void m_clear();
    for (int i = 0; i < 16; i++) m_val[i] = 1'b0;
    m_busy = 16;
  endfunction

  task automatic step(input logic [29:0] a,
                      input logic e, input logic f,
                      input logic s, input logic k,
                      input logic [31:0] d);
    logic [3:0] idx;
    logic       eh;
    bus.ich_adr   = a;
    bus.ich_ena   = e;
    bus.ich_flush = f;
    bus.iwb_stb_o = s;
    bus.iwb_ack_i = k;
    bus.iwb_dat_i = d;
    #1;
    idx = a[3:0];
    eh  = (m_busy == 0) && e && m_val[idx]
       && (m_tag[idx] == a[29:4]);
    chk("hit", {31'd0, bus.ich_hit}, {31'd0, eh});
    chk("busy", {31'd0, bus.ich_busy},
        {31'd0, m_busy != 0});
    if (eh) chk("dat", bus.ich_dat, m_dat[idx]);
    l_hit  = bus.ich_hit;
    l_busy = bus.ich_busy;
    l_dat  = bus.ich_dat;
    @(posedge gclk);
    if (!grst || f) begin
      m_clear();
    end else if (m_busy > 0) begin
      m_busy--;
    end else if (e && s && k) begin
      m_val[idx] = 1'b1;
      m_tag[idx] = a[29:4];
      m_dat[idx] = d;
    end
    @(negedge gclk);
  endtask

  task automatic look(input string tag,
                      input logic [29:0] a,
                      input logic eh,
                      input logic [31:0] ed);
    step(a, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk(tag, {31'd0, l_hit}, {31'd0, eh});
    if (eh) chk({tag, "_dat"}, l_dat, ed);
  endtask

  task automatic walk(input string tag, input logic k);
    int n;
    n = 0;
    for (int i = 0; i < 16; i++) begin
      step(30'h23, 1'b1, 1'b0, k, k, 32'hDEAD_BEEF);
      if (l_busy) n++;
    end
    chk(tag, n, 16);
    look({tag, "_ack_dropped"}, 30'h23, 1'b0, 32'h0);
    chk({tag, "_done"}, {31'd0, l_busy}, 32'd0);
  endtask

  task automatic fill(input logic [29:0] a,
                      input logic [31:0] d);
    step(a, 1'b1, 1'b0, 1'b1, 1'b1, d);
  endtask

  initial begin
    bus.ich_adr   = '0;
    bus.ich_ena   = 1'b1;
    bus.ich_flush = 1'b0;
    bus.iwb_stb_o = 1'b0;
    bus.iwb_ack_i = 1'b0;
    bus.iwb_dat_i = '0;
    m_clear();
    for (int i = 0; i < 16; i++) begin
      m_tag[i] = '0;
      m_dat[i] = '0;
    end
    @(negedge gclk);
    @(negedge gclk);
    for (int i = 0; i < 3; i++)
      step(30'h40, 1'b1, 1'b0, 1'b1, 1'b1, 32'h1);
    grst = 1'b1;
    walk("init_busy", 1'b0);
    look("rst_miss40", 30'h40, 1'b0, 32'h0);
    look("rst_miss07", 30'h07, 1'b0, 32'h0);

    fill(30'h40, 32'hB800_0010);
    look("fill40", 30'h40, 1'b1, 32'hB800_0010);
    look("alias50", 30'h50, 1'b0, 32'h0);
    fill(30'h50, 32'h1234_5678);
    look("fill50", 30'h50, 1'b1, 32'h1234_5678);
    look("evict40", 30'h40, 1'b0, 32'h0);
    fill(30'h22, 32'hCAFE_0022);
    look("fill22", 30'h22, 1'b1, 32'hCAFE_0022);

    step(30'h22, 1'b1, 1'b1, 1'b1, 1'b1, 32'h5);
    walk("flush_busy", 1'b1);
    look("flush50", 30'h50, 1'b0, 32'h0);
    look("flush22", 30'h22, 1'b0, 32'h0);

    step(30'h41, 1'b0, 1'b0, 1'b1, 1'b1, 32'hAAAA_5555);
    look("ena0_fill", 30'h41, 1'b0, 32'h0);
    fill(30'h41, 32'h5555_AAAA);
    step(30'h41, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("ena0_hit", {31'd0, l_hit}, 32'd0);
    look("ena1_hit", 30'h41, 1'b1, 32'h5555_AAAA);

    step(30'h41, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 7; i++)
      step(30'h41, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    grst = 1'b0;
    m_clear();
    step(30'h41, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step(30'h41, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    grst = 1'b1;
    walk("rst_mid_flush", 1'b0);
    look("rst41", 30'h41, 1'b0, 32'h0);

    for (int i = 0; i < 1500; i++) begin
      step(30'($urandom_range(0, 63)),
           ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 49) == 0),
           1'($urandom), 1'($urandom), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
